// File: rtl/regwb_queue.sv
// Register write-back queue: small circular FIFO of pending {rd, data} results drained
// into the register file. Define REGWB_QUEUE_BYPASS_EN to enable pending-value forwarding.
module regwb_queue #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_rd,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       drain_en,
    input  logic                       flush,
    output logic                       regWrite,
    output logic [4:0]                 writeReg,
    output logic [WIDTH-1:0]           dataWrite,
    input  logic [4:0]                 lookup1,
    input  logic [4:0]                 lookup2,
    output logic                       hit1,
    output logic                       hit2,
    output logic [WIDTH-1:0]           fwd_data1,
    output logic [WIDTH-1:0]           fwd_data2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [4:0]       rd_q   [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop, not_empty;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q != CntW'(DEPTH));
    // rd == 0 handshakes complete but never occupy a slot.
    assign push      = in_valid && in_ready && !flush && (in_rd != 5'd0);
    assign regWrite  = not_empty && drain_en;
    assign pop       = regWrite;
    assign writeReg  = not_empty ? rd_q[head_q] : '0;
    assign dataWrite = not_empty ? data_q[head_q] : '0;
    assign count     = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PtrW'(1);
            if (pop)  head_d = head_q + PtrW'(1);
            if (push && !pop)      count_d = count_q + CntW'(1);
            else if (!push && pop) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail_q]   <= in_rd;
            data_q[tail_q] <= in_data;
        end
    end

`ifdef REGWB_QUEUE_BYPASS_EN
    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit1      = 1'b0;
        hit2      = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CntW'(i) < count_q) begin
                if ((lookup1 != 5'd0) && (rd_q[head_q + PtrW'(i)] == lookup1)) begin
                    hit1      = 1'b1;
                    fwd_data1 = data_q[head_q + PtrW'(i)];
                end
                if ((lookup2 != 5'd0) && (rd_q[head_q + PtrW'(i)] == lookup2)) begin
                    hit2      = 1'b1;
                    fwd_data2 = data_q[head_q + PtrW'(i)];
                end
            end
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = ^{lookup1, lookup2};
    assign hit1      = 1'b0;
    assign hit2      = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule

// File: doc/regwb_queue.md
REGWB_QUEUE -- requirements
Module: regwb_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 64: data width of each write entry.
REQ-002 SHALL have parameter DEPTH, default 4, a power of two of at least 2: number of pending write entries.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: producer offers a result.
REQ-006 SHALL have port in_ready, output, 1 bit: queue can accept a result.
REQ-007 SHALL have port in_rd, input, 5 bits: destination register index.
REQ-008 SHALL have port in_data, input, WIDTH bits: result value.
REQ-009 SHALL have port drain_en, input, 1 bit: register-file write port is available this cycle.
REQ-010 SHALL have port flush, input, 1 bit: discard all pending entries.
REQ-011 SHALL have port regWrite, output, 1 bit: write strobe to the register file.
REQ-012 SHALL have port writeReg, output, 5 bits: register-file write index.
REQ-013 SHALL have port dataWrite, output, WIDTH bits: register-file write data.
REQ-014 SHALL have ports lookup1 and lookup2, input, 5 bits each: source indices being read.
REQ-015 SHALL have ports hit1 and hit2, output, 1 bit each: a pending entry matches the corresponding lookup.
REQ-016 SHALL have ports fwd_data1 and fwd_data2, output, WIDTH bits each: forwarded pending value.
REQ-017 SHALL have port count, output, $clog2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-018 SHALL be a circular FIFO with head and tail pointers that wrap modulo DEPTH.
REQ-019 SHALL drive in_ready = (count != DEPTH); the ready signal SHALL NOT depend on a same-cycle drain.
REQ-020 SHALL enqueue {in_rd, in_data} at the tail on a clock edge where in_valid && in_ready && !flush && in_rd != 0.
REQ-021 SHALL accept and silently drop a handshake with in_rd == 0, with no change to count.
REQ-022 SHALL drive regWrite = (count != 0) && drain_en, combinationally, with writeReg and dataWrite equal to the head entry.
REQ-023 SHALL drive writeReg = 0 and dataWrite = 0 when count == 0.
REQ-024 SHALL pop the head on the edge where regWrite = 1, giving one-cycle latency from enqueue to earliest regWrite.
REQ-025 SHALL leave count unchanged on a simultaneous enqueue and pop, and SHALL advance both pointers.
REQ-026 SHALL give flush priority: on the flush edge, count becomes 0, pointers reset, and any enqueue is ignored; regWrite SHALL still be driven combinationally during the flush cycle.
REQ-027 SHALL, for each lookup port, set the hit output to 1 if any valid entry has rd equal to the lookup index; lookup index 0 never hits.
REQ-028 SHALL, on multiple matches, return the data of the youngest entry (closest to the tail).
REQ-029 SHALL drive fwd_dataN = 0 when hitN = 0.
REQ-030 SHALL compute lookup combinationally over stored entries only; the same-cycle in_data is not forwarded.

Reset
REQ-031 SHALL, on rst_n low, immediately set count = 0, head = 0, tail = 0, and make regWrite, hit1 and hit2 equal to 0, without waiting for clk.
REQ-032 SHALL discard all pending entries when reset is asserted mid-operation; entry storage need not be cleared.
REQ-033 SHALL have in_ready = 1 after reset deassertion.

Configuration
REQ-034 SHALL, with macro REGWB_QUEUE_BYPASS_EN defined, implement REQ-027 to REQ-030 as written.
REQ-035 SHALL, without REGWB_QUEUE_BYPASS_EN, tie hit1, hit2, fwd_data1 and fwd_data2 to 0, remove the lookup logic, and leave all other behaviour identical.

Verification
REQ-036 SHALL cover: enqueue rd=5, data=0xAA with drain_en=1 -> next cycle regWrite=1, writeReg=5, dataWrite=0xAA; the following cycle count=0.
REQ-037 SHALL cover: drain_en=0 and 4 enqueues (rd=1..4) -> count=4, in_ready=0; a 5th offer is not accepted; drain_en=1 -> writes 1, 2, 3, 4 in order over 4 cycles.
REQ-038 SHALL cover: enqueue rd=0, data=0xFF -> count remains 0 and regWrite is never asserted.
REQ-039 SHALL cover, with REGWB_QUEUE_BYPASS_EN defined: enqueue rd=7/0x11, then rd=7/0x22, with drain_en=0 and lookup1=7 -> hit1=1, fwd_data1=0x22; lookup2=0 -> hit2=0.
REQ-040 SHALL cover: count=3, then flush=1 together with in_valid=1 -> next cycle count=0, and the new entry is absent.
REQ-041 SHALL cover: count=2, then rst_n pulsed low between clock edges -> count=0 and regWrite=0 immediately; after release in_ready=1.
